// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
//   data_t       byte carried on the TX datapath
//   arb_state_t  sequencing states of uart_tx_arbiter
//   wdog_t       width of the frame watchdog counter
package uart_pkg;

   typedef logic [7:0] data_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      START,
      BUSY
   } arb_state_t;

   localparam int NREQ_DEF = 4;
   localparam int WDOG_DEF = 65535;

   typedef logic [15:0] wdog_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection, purely combinational.
// Ports:
//   req_i     request vector, bit i belongs to requester i
//   ptr_i     index that has highest priority this round
//   winner_o  first requester at or after ptr_i, wrapping
//   valid_o   at least one request is set
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [$clog2(NREQ)-1:0] winner_o,
   output logic                    valid_o
);

   localparam int IW = $clog2(NREQ);
   localparam logic [IW:0] N_W = (IW+1)'(NREQ);

   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic [IW-1:0]     idx;
   logic [IW:0]       sum;

   always_comb begin
      // Rotate so ptr_i lands at bit 0, take the lowest set bit, then undo
      // the rotation by adding ptr_i back modulo NREQ.
      req_dbl = {req_i, req_i};
      req_rot = req_dbl[ptr_i +: NREQ];
      idx     = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_rot[i]) idx = IW'(i);
      end
      sum = {1'b0, idx} + {1'b0, ptr_i};
      if (sum >= N_W) sum = sum - N_W;
      winner_o = sum[IW-1:0];
      valid_o  = |req_i;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART TX datapath among NREQ
// requesters, with a watchdog bounding the wait on tx_done.
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   req        level requests; req_data holds requester i at [i*DW +: DW]
//   gnt        one-hot, one-cycle acknowledge that the byte was captured
//   tx_start   one-cycle start pulse; tx_data is the captured byte
//   tx_done    end-of-frame pulse from the datapath
//   busy       high from grant until the frame ends
//   owner      current or last granted requester
//   tout_err   one-cycle pulse when the watchdog abandons a frame
//
// state | meaning
// IDLE  | waiting for any request; picks winner and captures its byte
// GRANT | acknowledging the winner
// START | pulsing tx_start, arming the watchdog
// BUSY  | waiting for tx_done or watchdog expiry
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = $bits(data_t),
   parameter int WDOG = WDOG_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*DW-1:0]      req_data,
   output logic [NREQ-1:0]         gnt,
   output logic                    tx_start,
   output logic [DW-1:0]           tx_data,
   input  logic                    tx_done,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    tout_err
);

   localparam int    IW      = $clog2(NREQ);
   // Down-counter loaded in START; zero in BUSY marks the WDOG-th busy cycle.
   localparam wdog_t WDOG_TC = wdog_t'(WDOG - 1);

   arb_state_t    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [DW-1:0] data_q, data_d;
   wdog_t         wdog_q, wdog_d;

   logic [IW-1:0] pick_w;
   logic          pick_valid;
   logic [IW-1:0] next_ptr;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .winner_o (pick_w),
      .valid_o  (pick_valid)
   );

   assign next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         data_q  <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         data_q  <= data_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      data_d   = data_q;
      wdog_d   = wdog_q;
      gnt      = '0;
      tx_start = 1'b0;
      busy     = 1'b0;
      tout_err = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d = pick_w;
               for (int i = 0; i < NREQ; i++) begin
                  if (pick_w == IW'(i)) data_d = req_data[i*DW +: DW];
               end
               state_d = GRANT;
            end
         end
         GRANT: begin
            busy         = 1'b1;
            gnt[owner_q] = 1'b1;
            state_d      = START;
         end
         START: begin
            busy     = 1'b1;
            tx_start = 1'b1;
            wdog_d   = WDOG_TC;
            state_d  = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            // tx_done takes priority over a simultaneous watchdog expiry.
            if (tx_done) begin
               ptr_d   = next_ptr;
               state_d = IDLE;
            end else if (wdog_q == '0) begin
               tout_err = 1'b1;
               ptr_d    = next_ptr;
               state_d  = IDLE;
            end else begin
               wdog_d = wdog_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_data = data_q;
   assign owner   = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=4, DW=8, WDOG=50).
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        busy;
   logic [1:0]  owner;
   logic        tout_err;

   int checks   = 0;
   int failures = 0;

   uart_tx_arbiter #(
      .NREQ (4),
      .DW   (8),
      .WDOG (50)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_done  (tx_done),
      .busy     (busy),
      .owner    (owner),
      .tout_err (tout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL time_limit: got timeout required completion");
      $fatal(1, "time limit");
   end

   typedef struct {
      int          rep;
      logic        rst;
      logic [3:0]  req;
      logic [31:0] data;
      logic        done;
      logic [3:0]  e_gnt;
      logic        e_start;
      logic [7:0]  e_data;
      logic        e_busy;
      logic [1:0]  e_owner;
      logic        e_terr;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs[NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Entered at the drive point of the GRANT cycle; returns at the drive
   // point two cycles after tx_done (the earliest possible next GRANT).
   task automatic frame(input int eo, input logic [7:0] ed, input int done_after,
                        input logic [3:0] req_after);
      logic [3:0] eg;
      eg     = '0;
      eg[eo] = 1'b1;
      settle();
      chk("frm_gnt", 32'(gnt), 32'(eg));
      chk("frm_owner", 32'(owner), 32'(eo));
      chk("frm_data_at_gnt", 32'(tx_data), 32'(ed));
      chk("frm_start_early", 32'(tx_start), 32'd0);
      next_cycle();
      req = req_after;
      settle();
      chk("frm_start", 32'(tx_start), 32'd1);
      chk("frm_data_at_start", 32'(tx_data), 32'(ed));
      chk("frm_gnt_once", 32'(gnt), 32'd0);
      repeat (done_after) next_cycle();
      tx_done = 1'b1;
      settle();
      chk("frm_busy_at_done", 32'(busy), 32'd1);
      chk("frm_terr_at_done", 32'(tout_err), 32'd0);
      chk("frm_data_at_done", 32'(tx_data), 32'(ed));
      next_cycle();
      tx_done = 1'b0;
      settle();
      chk("frm_gap_busy", 32'(busy), 32'd0);
      chk("frm_gap_gnt", 32'(gnt), 32'd0);
      chk("frm_hold_data", 32'(tx_data), 32'(ed));
      chk("frm_hold_owner", 32'(owner), 32'(eo));
      next_cycle();
   endtask

   initial begin
      int bad;
      // rep rst req data done | gnt start data busy owner terr
      vecs[0] = '{3,  1'b0, 4'h0, 32'h0,         1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      vecs[1] = '{10, 1'b1, 4'h0, 32'h0,         1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      vecs[2] = '{1,  1'b1, 4'h0, 32'h0,         1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      vecs[3] = '{2,  1'b1, 4'h0, 32'h0,         1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      vecs[4] = '{1,  1'b1, 4'h4, 32'hC3A55A3C, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      vecs[5] = '{1,  1'b1, 4'h4, 32'hC3A55A3C, 1'b0, 4'h4, 1'b0, 8'hA5, 1'b1, 2'd2, 1'b0};
      vecs[6] = '{1,  1'b1, 4'h0, 32'hC3A55A3C, 1'b0, 4'h0, 1'b1, 8'hA5, 1'b1, 2'd2, 1'b0};
      vecs[7] = '{17, 1'b1, 4'h0, 32'hC3A55A3C, 1'b0, 4'h0, 1'b0, 8'hA5, 1'b1, 2'd2, 1'b0};
      vecs[8] = '{1,  1'b1, 4'h0, 32'hC3A55A3C, 1'b1, 4'h0, 1'b0, 8'hA5, 1'b1, 2'd2, 1'b0};
      vecs[9] = '{3,  1'b1, 4'h0, 32'hC3A55A3C, 1'b0, 4'h0, 1'b0, 8'hA5, 1'b0, 2'd2, 1'b0};

      rst = 1'b0; req = '0; req_data = '0; tx_done = 1'b0;

      // Reset, idle, ignored tx_done, single requester 2.
      for (int v = 0; v < NV; v++) begin
         for (int r = 0; r < vecs[v].rep; r++) begin
            rst      = vecs[v].rst;
            req      = vecs[v].req;
            req_data = vecs[v].data;
            tx_done  = vecs[v].done;
            settle();
            chk($sformatf("vec%0d_gnt", v),   32'(gnt),      32'(vecs[v].e_gnt));
            chk($sformatf("vec%0d_start", v), 32'(tx_start), 32'(vecs[v].e_start));
            chk($sformatf("vec%0d_data", v),  32'(tx_data),  32'(vecs[v].e_data));
            chk($sformatf("vec%0d_busy", v),  32'(busy),     32'(vecs[v].e_busy));
            chk($sformatf("vec%0d_owner", v), 32'(owner),    32'(vecs[v].e_owner));
            chk($sformatf("vec%0d_terr", v),  32'(tout_err), 32'(vecs[v].e_terr));
            next_cycle();
         end
      end

      // Wrap plus skip: ptr=3 after serving 2, req=1001 -> 3 then 0.
      req      = 4'b1001;
      req_data = 32'h3C0000C0;
      next_cycle();
      frame(3, 8'h3C, 12, 4'b0001);
      frame(0, 8'hC0, 12, 4'b0000);

      // ptr is now 1: req=1011 must pick 1. Then let the watchdog expire.
      req      = 4'b1011;
      req_data = 32'h3B005B1A;
      next_cycle();
      settle();
      chk("wd_gnt", 32'(gnt), 32'h2);
      chk("wd_owner", 32'(owner), 32'd1);
      chk("wd_data", 32'(tx_data), 32'h5B);
      next_cycle();
      req = 4'b1000;
      settle();
      chk("wd_start", 32'(tx_start), 32'd1);
      bad = 0;
      for (int k = 1; k < 50; k++) begin
         next_cycle();
         settle();
         if (tout_err !== 1'b0 || busy !== 1'b1) bad++;
      end
      chk("wd_early_abort", 32'(bad), 32'd0);
      next_cycle();
      settle();
      chk("wd_terr", 32'(tout_err), 32'd1);
      chk("wd_terr_busy", 32'(busy), 32'd1);
      next_cycle();
      settle();
      chk("wd_after_terr", 32'(tout_err), 32'd0);
      chk("wd_after_busy", 32'(busy), 32'd0);
      next_cycle();
      // Requester 3 granted 2 cycles after the abort; its tx_done lands on
      // the terminal count, so no error.
      frame(3, 8'h3B, 50, 4'b0000);

      // Reset in the middle of a frame.
      req      = 4'b0100;
      req_data = 32'h00776600;
      next_cycle();
      settle();
      chk("mr_gnt", 32'(gnt), 32'h4);
      next_cycle();
      req = 4'b0000;
      repeat (3) next_cycle();
      rst = 1'b0;
      settle();
      chk("mr_busy_before", 32'(busy), 32'd1);
      next_cycle();
      rst = 1'b1;
      req = 4'b0010;
      settle();
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_data", 32'(tx_data), 32'd0);
      chk("mr_owner", 32'(owner), 32'd0);
      chk("mr_start", 32'(tx_start), 32'd0);
      chk("mr_gnt_off", 32'(gnt), 32'd0);
      next_cycle();
      frame(1, 8'h66, 5, 4'b0000);

      // Round-robin with all requests held, from reset.
      rst      = 1'b0;
      req      = 4'b1111;
      req_data = 32'h13121110;
      next_cycle();
      rst = 1'b1;
      settle();
      chk("rr_reset_busy", 32'(busy), 32'd0);
      next_cycle();
      for (int f = 0; f < 5; f++) begin
         frame(f % 4, 8'h10 + 8'(f % 4), 12, 4'b1111);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmit datapath among NREQ requesters.
- Each requester presents a byte with a level request. The arbiter picks one requester, latches its byte, acknowledges it, pulses the start input of the TX datapath, then holds ownership until the datapath reports frame completion.
- A watchdog bounds the wait on tx_done so a stuck datapath cannot block requesters forever.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, byte width; must equal the width of data_t.
- WDOG, 65535, maximum cycles spent in BUSY before abort.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset.
- req  input  NREQ  per-requester level request; bit i belongs to requester i.
- req_data  input  NREQ*DW  packed bytes; requester i occupies bits [i*DW +: DW].
- gnt  output  NREQ  one-hot, one-cycle acknowledge; req_data[i] has been captured.
- tx_start  output  1  one-cycle start pulse to the TX datapath.
- tx_data  output  DW  registered byte to the TX datapath, stable from tx_start until tx_done.
- tx_done  input  1  one-cycle pulse from the TX datapath at end of stop bit.
- busy  output  1  high in GRANT, START and BUSY states.
- owner  output  $clog2(NREQ)  index of the current or last granted requester.
- tout_err  output  1  one-cycle pulse when the watchdog aborts a frame.

Behaviour:
- Everything is sampled on the rising edge of clk. When rst==0, state goes to IDLE, ptr=0, wdog count=0, and gnt, tx_start, tx_data, busy, owner, tout_err are all 0.
- States (arb_state_t): IDLE, GRANT, START, BUSY.
- IDLE:
  - If req != 0, select winner w = first set bit of req searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - Register owner<=w and tx_data<=req_data[w], go to GRANT.
  - If req == 0, stay in IDLE.
- GRANT: gnt[w]=1 for exactly this cycle, go to START.
- START: tx_start=1 for exactly this cycle, clear wdog count, go to BUSY.
- BUSY:
  - Increment wdog count every cycle.
  - On tx_done: set ptr<=(w+1) mod NREQ and go to IDLE.
  - If the count reaches WDOG with no tx_done: pulse tout_err, set ptr<=(w+1) mod NREQ, go to IDLE.
  - If tx_done and the WDOG terminal count occur in the same cycle, tx_done wins and tout_err stays 0.
- Latency: req sampled high in IDLE at cycle N gives gnt at N+1 and tx_start at N+2. The earliest next grant comes 2 cycles after tx_done (IDLE re-evaluates, then GRANT), giving a fixed 1-cycle inter-frame gap.
- tx_done outside BUSY is ignored; no state change, no error.
- Requesters:
  - Requests are level. A requester keeps req[i] high until gnt[i], then drops it or re-raises it for the next byte.
  - A request dropped before the IDLE sampling edge is not granted.
  - A request withdrawn after selection (during GRANT) still receives gnt, and its byte is still sent; data was already captured.
  - req_data[i] only needs to be stable on the cycle req is sampled in IDLE.
- Fairness: after serving w, the next search starts at w+1. With all requests held high, service order is 0,1,2,3,0,... and no requester waits more than NREQ-1 frames.
- ptr wrap: w=NREQ-1 gives ptr=0.
- tx_data and owner hold their values after return to IDLE until the next selection.
- Reset mid-frame: the arbiter returns to IDLE immediately and tx_start is not reissued. The TX datapath is reset by the same rst.

Decomposition:
- uart_pkg gains:
  - arb_state_t enum {IDLE, GRANT, START, BUSY};
  - constants NREQ_DEF=4 and WDOG_DEF=65535;
  - typedef wdog_t = logic [15:0].
  - It reuses the existing data_t.
- One combinational sub-module, rr_pick: inputs req[NREQ] and ptr; outputs winner index and a valid flag. It uses a rotate / priority-encode / unrotate scheme.
- The FSM, registers and watchdog stay in uart_tx_arbiter.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then 1 with req=0 -> all outputs 0 for 10 cycles; tx_done pulses in IDLE are ignored.
- Single requester: req=4'b0100, req_data[2]=8'hA5 at cycle N -> gnt=4'b0100 at N+1, tx_start=1 with tx_data=8'hA5 at N+2, busy stays high until tx_done at N+20, owner=2.
- Round-robin: req=4'b1111 held, data bytes 8'h10,8'h11,8'h12,8'h13, tx_done 12 cycles after each start -> grant order 0,1,2,3,0 and the tx_data sequence matches.
- Wrap plus skip: ptr=3 after serving 2, req=4'b1001 -> grant 3 first then 0; ptr ends at 1.
- Watchdog: WDOG=50, no tx_done after start -> tout_err pulse 50 cycles after tx_start, return to IDLE, next pending requester granted 2 cycles later. Also cover tx_done coinciding with the terminal count -> tout_err=0.
- Reset mid-frame: rst=0 during BUSY -> next cycle state IDLE, busy=0, ptr=0, tx_data=0; after release with req=4'b0010, gnt=4'b0010 one cycle after sampling.
